stream_pattern_gen: RTL
=======================

// Module: stream_pattern_gen
// PURPOSE
//  Pixel-clock-domain frame source that drives the sensor-side stream protocol (o_fval/o_lval/ov_pix_data)
//  consumed by stream_ctrl/sync_buffer; transmitter counterpart of that receive path.
//  Replaces the physical sensor for FPGA self-test and data-path bring-up; emits deterministic patterns
//  so the downstream checker can verify every pixel.
// PARAMETERS
//  SENSOR_DAT_WIDTH  10   bits per pixel per channel
//  CHANNEL_NUM       4    pixels output per clock
//  REG_WD            32   register bus width; geometry inputs use [15:0] of it
// PORTS
//  clk_pix          in   1                          pixel clock
//  rst_pix_n        in   1                          async active-low reset
//  i_clk_en         in   1                          0 freezes all state and outputs
//  i_acq_en         in   1                          1 = generate frames; sampled only in IDLE/VBLANK exit
//  iv_width         in   REG_WD                     active clocks per line ([15:0])
//  iv_height        in   REG_WD                     lines per frame ([15:0])
//  iv_h_blank       in   REG_WD                     lval-low clocks between lines ([15:0])
//  iv_v_blank       in   REG_WD                     fval-low clocks between frames ([15:0])
//  iv_pattern_sel   in   2                          0 pix-inc, 1 line-inc, 2 frame-inc, 3 fixed/random
//  iv_fixed_value   in   SENSOR_DAT_WIDTH           value for pattern 3 (without macro)
//  o_fval           out  1                          frame valid
//  o_lval           out  1                          line valid
//  ov_pix_data      out  SENSOR_DAT_WIDTH*CHANNEL_NUM  channel k in bits [k*W +: W]
//  ov_frame_cnt     out  16                         completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0. All outputs registered; i_clk_en=0 holds everything.
//  - FSM: IDLE -> LEAD (3 clk, fval=1 lval=0) -> LINE (width clk, lval=1) -> HBLANK (h_blank clk)
//    -> LINE ... last line -> TAIL (3 clk, fval=1 lval=0) -> VBLANK (v_blank clk, fval=0) -> LEAD or IDLE.
//  - No HBLANK after the last line; LINE goes directly to TAIL.
//  - IDLE->LEAD when i_acq_en=1 and width!=0 and height!=0; o_fval rises on the clock after the transition.
//  - Geometry and pattern_sel latched on entry to LEAD; changes mid-frame apply next frame only.
//  - h_blank=0 or v_blank=0 treated as 1 (lval/fval always drop for at least 1 clock).
//  - i_acq_en=0 mid-frame: the current frame completes in full; at VBLANK end go to IDLE. Never truncated.
//  - width or height=0 at latch point: remain/return IDLE, no fval pulse.
//  - Pixel data (0 whenever lval=0), x=clock index in line, y=line index, f=ov_frame_cnt; all mod 2^W:
//    pat0 = x*CHANNEL_NUM+k; pat1 = y; pat2 = f; pat3 = iv_fixed_value (latched).
//  - ov_frame_cnt increments on the clock o_fval falls.
//  - Async reset mid-frame: fval/lval drop immediately; restart from IDLE.
// CONFIGURATION
//  - PATTERN_GEN_RANDOM_EN defined: pat3 = per-channel 16-bit LFSR (x^16+x^14+x^13+x^11+1),
//    seeds 16'hACE1+k, advancing only while lval=1; low W bits output; reseeded at each LEAD entry.
//  - Not defined: pat3 = latched iv_fixed_value; no LFSR logic.
// STRUCTURE
//  - Shared package: FSM state encoding, LEAD/TAIL length constant (3), pattern_sel codes,
//    LFSR seed/taps.
//  - One sub-module: stream_pattern_lfsr (one instance per channel, generated only under macro).
//  - FSM plus x/y/blank counters remain in this module.
// TESTING
//  - width=16 height=4 h_blank=8 v_blank=20 pat0 acq=1: each line has 16 lval clocks;
//    ch0 x=0..15 gives 0,4..60 and ch3 gives 3..63; 4 lval pulses per fval; fval high = 3+64+24+3 = 94 clk.
//  - pat1, height=5: lines carry data 0,1,2,3,4 on all channels; pat2 over 3 frames: data 0,1,2;
//    ov_frame_cnt=3.
//  - Drop acq_en at line 2 of frame 0 (height=4): frame completes with 4 lines, one VBLANK,
//    then IDLE with fval=0.
//  - Change width 16->8 mid-frame: the current frame keeps 16; the next frame uses 8.
//    width=0 at acq=1: fval never rises.
//  - h_blank=0, v_blank=0: lval low exactly 1 clk between lines; fval low exactly 1 clk.
//    i_clk_en toggled 1/0: output period doubles, data identical.
//  - Assert rst_pix_n low mid-line: outputs 0 asynchronously; after release with acq=1,
//    a clean 3-clk LEAD precedes the first lval.
//    With PATTERN_GEN_RANDOM_EN, pat3 ch0 first pixels match the reference LFSR from 16'hACE1 each frame.

Source files
------------

// File: rtl/stream_pattern_gen_pkg.sv
// Shared definitions for the stream_pattern_gen frame source: FSM encoding,
// frame edge length, pattern select codes and LFSR seed/taps.
package stream_pattern_gen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEAD   = 3'd1;
  localparam state_t ST_LINE   = 3'd2;
  localparam state_t ST_HBLANK = 3'd3;
  localparam state_t ST_TAIL   = 3'd4;
  localparam state_t ST_VBLANK = 3'd5;

  // fval=1/lval=0 clocks before the first line and after the last line
  localparam logic [15:0] EDGE_LEN  = 16'd3;
  localparam logic [15:0] EDGE_LAST = EDGE_LEN - 16'd1;

  localparam logic [1:0] PAT_PIX_INC   = 2'd0;
  localparam logic [1:0] PAT_LINE_INC  = 2'd1;
  localparam logic [1:0] PAT_FRAME_INC = 2'd2;
  localparam logic [1:0] PAT_FIXED     = 2'd3;

  // x^16+x^14+x^13+x^11+1, Fibonacci form shifting right; feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] h_blank;
    logic [15:0] v_blank;
    logic [1:0]  pat_sel;
  } frame_cfg_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

endpackage

// File: rtl/stream_pattern_lfsr.sv
// Per-channel 16-bit LFSR for the random test pattern; reloads its seed on
// i_load and steps once per clock while i_advance is high.
module stream_pattern_lfsr
  import stream_pattern_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clk_en,
  input  logic        i_load,
  input  logic        i_advance,
  output logic [15:0] o_state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_state <= SEED;
    end else if (i_clk_en) begin
      if (i_load) begin
        o_state <= SEED;
      end else if (i_advance) begin
        o_state <= lfsr_next(o_state);
      end
    end
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// Pixel-clock frame source driving o_fval/o_lval/ov_pix_data with deterministic
// test patterns. Define PATTERN_GEN_RANDOM_EN to make pattern 3 a per-channel LFSR.
module stream_pattern_gen
  import stream_pattern_gen_pkg::*;
#(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32
) (
  input  logic                                    clk_pix,
  input  logic                                    rst_pix_n,
  input  logic                                    i_clk_en,
  input  logic                                    i_acq_en,
  input  logic [REG_WD-1:0]                       iv_width,
  input  logic [REG_WD-1:0]                       iv_height,
  input  logic [REG_WD-1:0]                       iv_h_blank,
  input  logic [REG_WD-1:0]                       iv_v_blank,
  input  logic [1:0]                              iv_pattern_sel,
  input  logic [SENSOR_DAT_WIDTH-1:0]             iv_fixed_value,
  output logic                                    o_fval,
  output logic                                    o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic [15:0]                             ov_frame_cnt
);

  localparam int W = SENSOR_DAT_WIDTH;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [15:0]               r_cnt;
  logic [15:0]               w_cnt_nxt;
  logic [15:0]               r_y;
  logic [15:0]               w_y_nxt;
  frame_cfg_t                r_cfg;
  frame_cfg_t                w_cfg_in;
  logic [W-1:0]              r_fixed;
  logic                      w_start;
  logic                      w_lead_entry;
  logic                      w_frame_done;
  logic                      w_fval_nxt;
  logic                      w_lval_nxt;
  logic [W*CHANNEL_NUM-1:0]  w_pix_nxt;
  logic                      w_unused_hi;

  assign w_unused_hi = &{iv_width[REG_WD-1:16], iv_height[REG_WD-1:16],
                         iv_h_blank[REG_WD-1:16], iv_v_blank[REG_WD-1:16]};

  assign w_start = i_acq_en && (iv_width[15:0] != 16'd0) && (iv_height[15:0] != 16'd0);

  // Zero blanking is widened to one clock so lval/fval always drop between lines/frames
  always_comb begin
    w_cfg_in.width   = iv_width[15:0];
    w_cfg_in.height  = iv_height[15:0];
    w_cfg_in.h_blank = (iv_h_blank[15:0] == 16'd0) ? 16'd1 : iv_h_blank[15:0];
    w_cfg_in.v_blank = (iv_v_blank[15:0] == 16'd0) ? 16'd1 : iv_v_blank[15:0];
    w_cfg_in.pat_sel = iv_pattern_sel;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_y_nxt      = r_y;
    w_lead_entry = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start) begin
          w_state_nxt  = ST_LEAD;
          w_lead_entry = 1'b1;
        end
      end
      ST_LEAD: begin
        if (r_cnt == EDGE_LAST) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = '0;
          w_y_nxt     = '0;
        end
      end
      ST_LINE: begin
        if (r_cnt == r_cfg.width - 16'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_y == r_cfg.height - 16'd1) ? ST_TAIL : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == r_cfg.h_blank - 16'd1) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = '0;
          w_y_nxt     = r_y + 16'd1;
        end
      end
      ST_TAIL: begin
        if (r_cnt == EDGE_LAST) begin
          w_state_nxt  = ST_VBLANK;
          w_cnt_nxt    = '0;
          w_frame_done = 1'b1;
        end
      end
      ST_VBLANK: begin
        if (r_cnt == r_cfg.v_blank - 16'd1) begin
          w_cnt_nxt = '0;
          if (w_start) begin
            w_state_nxt  = ST_LEAD;
            w_lead_entry = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state
  assign w_fval_nxt = (w_state_nxt == ST_LEAD) || (w_state_nxt == ST_LINE) ||
                      (w_state_nxt == ST_HBLANK) || (w_state_nxt == ST_TAIL);
  assign w_lval_nxt = (w_state_nxt == ST_LINE);

  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_ch
    logic [W-1:0] w_pat3;
    logic [W-1:0] w_val;

`ifdef PATTERN_GEN_RANDOM_EN
    logic [15:0] w_lfsr_state;

    stream_pattern_lfsr #(
      .SEED(LFSR_SEED + 16'(k))
    ) u_lfsr (
      .clk       (clk_pix),
      .rst_n     (rst_pix_n),
      .i_clk_en  (i_clk_en),
      .i_load    (w_lead_entry),
      .i_advance (w_lval_nxt),
      .o_state   (w_lfsr_state)
    );

    assign w_pat3 = W'(w_lfsr_state);
`else
    assign w_pat3 = r_fixed;
`endif

    always_comb begin
      case (r_cfg.pat_sel)
        PAT_PIX_INC:   w_val = W'(32'(w_cnt_nxt) * CHANNEL_NUM + k);
        PAT_LINE_INC:  w_val = W'(w_y_nxt);
        PAT_FRAME_INC: w_val = W'(ov_frame_cnt);
        default:       w_val = w_pat3;
      endcase
    end

    assign w_pix_nxt[k*W +: W] = w_lval_nxt ? w_val : '0;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_y          <= '0;
      r_cfg        <= '0;
      r_fixed      <= '0;
      o_fval       <= 1'b0;
      o_lval       <= 1'b0;
      ov_pix_data  <= '0;
      ov_frame_cnt <= '0;
    end else if (i_clk_en) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_y         <= w_y_nxt;
      o_fval      <= w_fval_nxt;
      o_lval      <= w_lval_nxt;
      ov_pix_data <= w_pix_nxt;
      if (w_lead_entry) begin
        r_cfg   <= w_cfg_in;
        r_fixed <= iv_fixed_value;
      end
      if (w_frame_done) begin
        ov_frame_cnt <= ov_frame_cnt + 16'd1;
      end
    end
  end

endmodule
